// File: rtl/shift_register_with_valid_ready_pkg.sv
// Shared helpers for the valid/ready delay line.
//   count_width(depth) : bits needed to hold an occupancy of 0..depth.
package shift_register_with_valid_ready_pkg;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_register_with_valid_ready_stage.sv
// One stage of the delay line: a valid flag plus a data word.
// Ports:
//   clk, rst     : clock, async active-low reset (clears the valid flag only)
//   en_i         : stage advances (takes the source) this cycle
//   flush_i      : synchronous clear of the valid flag, overrides en_i
//   src_vld_i    : valid bit of the source (input port or previous stage)
//   src_data_i   : data of the source
//   vld_o/data_o : current stage contents
module pipe_stage_with_valid #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             src_vld_i,
  input  logic [width-1:0] src_data_i,
  output logic             vld_o,
  output logic [width-1:0] data_o
);

  logic             vld_q;
  logic [width-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (en_i) begin
      vld_q <= src_vld_i;
    end
  end

  // Data is left unreset and only loaded with a valid source, so a
  // bubble moving through never disturbs the held word.
  always_ff @(posedge clk) begin
    if (en_i && src_vld_i) begin
      data_q <= src_data_i;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/shift_register_with_valid_ready.sv
// Delay line of `depth` stages carrying data plus valid, with downstream
// backpressure, bubble collapsing, synchronous flush and occupancy count.
// Ports:
//   clk, rst          : clock, async active-low reset
//   flush             : clears all stages at the next edge, blocks input
//   in_vld, in_data   : upstream word; in_rdy says stage 0 can take it
//   out_vld, out_data : contents of the last stage; out_rdy from consumer
//   count             : number of valid stages
module shift_register_with_valid_ready
  import shift_register_with_valid_ready_pkg::*;
#(
  parameter int  width = 8,
  parameter int  depth = 8,
  localparam int CW    = count_width(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [width-1:0] in_data,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [width-1:0] out_data,
  input  logic             out_rdy,
  output logic [CW-1:0]    count
);

  logic [depth-1:0] stage_vld;
  logic [depth-1:0] stage_en;
  logic [depth-1:0] src_vld;
  logic [width-1:0] stage_data [depth];
  logic [width-1:0] src_data   [depth];

  logic          in_xfer;
  logic          out_xfer;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // A stage may advance when the consumer takes the last word or when any
  // stage between it and the output holds a bubble to fill.
  always_comb begin
    logic [depth-1:0] en_v;
    en_v = '0;
    en_v[depth-1] = out_rdy | ~stage_vld[depth-1];
    for (int i = depth - 2; i >= 0; i--) begin
      en_v[i] = en_v[i+1] | ~stage_vld[i];
    end
    stage_en = en_v;
  end

  for (genvar i = 0; i < depth; i++) begin : g_stage
    if (i == 0) begin : g_src_in
      assign src_vld[i]  = in_vld;
      assign src_data[i] = in_data;
    end else begin : g_src_prev
      assign src_vld[i]  = stage_vld[i-1];
      assign src_data[i] = stage_data[i-1];
    end

    pipe_stage_with_valid #(
      .width(width)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en_i      (stage_en[i]),
      .flush_i   (flush),
      .src_vld_i (src_vld[i]),
      .src_data_i(src_data[i]),
      .vld_o     (stage_vld[i]),
      .data_o    (stage_data[i])
    );
  end

  assign in_rdy   = stage_en[0] & ~flush;
  assign out_vld  = stage_vld[depth-1];
  assign out_data = stage_data[depth-1];
  assign in_xfer  = in_vld & in_rdy;
  assign out_xfer = out_vld & out_rdy;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifndef SYNTHESIS
  a_count_matches_vld: assert property (@(posedge clk) disable iff (!rst)
    count_q == CW'($countones(stage_vld)));
  a_no_xfer_without_vld: assert property (@(posedge clk) disable iff (!rst)
    out_xfer |-> out_vld);
`endif

endmodule

// File: tb/tb_shift_register_with_valid_ready.sv
module tb_shift_register_with_valid_ready;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush;
  logic       in_vld;
  logic [7:0] in_data;
  logic       out_rdy;

  // Instance 0 has depth 4 (directed tests); 1..3 have depths 1, 3, 8.
  logic [3:0]      in_rdy_v;
  logic [3:0]      out_vld_v;
  logic [3:0][7:0] out_data_v;
  logic [3:0][3:0] cnt_v;

  int n_vec = 0;
  int n_err = 0;

  function automatic int dep(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 3;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D  = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 3 : 8;
    localparam int CW = $clog2(D + 1);
    logic          ir;
    logic          ov;
    logic [7:0]    od;
    logic [CW-1:0] cnt;

    shift_register_with_valid_ready #(
      .width(8),
      .depth(D)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .in_vld  (in_vld),
      .in_data (in_data),
      .in_rdy  (ir),
      .out_vld (ov),
      .out_data(od),
      .out_rdy (out_rdy),
      .count   (cnt)
    );

    assign in_rdy_v[g]   = ir;
    assign out_vld_v[g]  = ov;
    assign out_data_v[g] = od;
    assign cnt_v[g]      = 4'(cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    flush = 0; in_vld = 0; in_data = 0; out_rdy = 1;
    rst = 0;
    #12;
    for (int g = 0; g < 4; g++) begin
      n_vec++;
      if (out_vld_v[g] !== 1'b0 || cnt_v[g] !== 4'd0 || in_rdy_v[g] !== 1'b1) begin
        n_err++;
        $display("FAIL reset[%0d]: out_vld=%b count=%0d in_rdy=%b, want 0/0/1",
                 g, out_vld_v[g], cnt_v[g], in_rdy_v[g]);
      end
    end
    tick();
    rst = 1;
    tick();
  endtask

  task automatic test_no_backpressure();
    int exp_cnt;
    int peak = 0;
    logic exp_v;
    out_rdy = 1;
    for (int c = 0; c < 8; c++) begin
      in_vld  = (c < 3);
      in_data = 8'(8'h11 * (c + 1));
      #1;
      exp_v = (c >= 4 && c <= 6);
      n_vec++;
      if (out_vld_v[0] !== exp_v) begin
        n_err++;
        $display("FAIL nobp_vld c%0d: got %b want %b", c, out_vld_v[0], exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (out_data_v[0] !== 8'(8'h11 * (c - 3))) begin
          n_err++;
          $display("FAIL nobp_data c%0d: got %h want %h", c, out_data_v[0], 8'(8'h11 * (c - 3)));
        end
      end
      exp_cnt = (c <= 3) ? c : 7 - c;
      n_vec++;
      if (cnt_v[0] !== 4'(exp_cnt)) begin
        n_err++;
        $display("FAIL nobp_count c%0d: got %0d want %0d", c, cnt_v[0], exp_cnt);
      end
      if (int'(cnt_v[0]) > peak) peak = int'(cnt_v[0]);
      tick();
    end
    in_vld = 0;
    n_vec++;
    if (peak !== 3) begin
      n_err++;
      $display("FAIL nobp_peak: got %0d want 3", peak);
    end
  endtask

  task automatic test_fill_full();
    out_rdy = 0;
    for (int c = 0; c < 6; c++) begin
      in_vld  = 1;
      in_data = 8'(8'hA0 + c);
      #1;
      n_vec++;
      if (in_rdy_v[0] !== (c < 4)) begin
        n_err++;
        $display("FAIL fill_rdy c%0d: got %b want %b", c, in_rdy_v[0], (c < 4));
      end
      n_vec++;
      if (cnt_v[0] !== 4'((c < 4) ? c : 4)) begin
        n_err++;
        $display("FAIL fill_count c%0d: got %0d want %0d", c, cnt_v[0], (c < 4) ? c : 4);
      end
      tick();
    end
    in_vld  = 0;
    out_rdy = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if (out_vld_v[0] !== (c < 4)) begin
        n_err++;
        $display("FAIL drain_vld c%0d: got %b want %b", c, out_vld_v[0], (c < 4));
      end
      if (c < 4) begin
        n_vec++;
        if (out_data_v[0] !== 8'(8'hA0 + c)) begin
          n_err++;
          $display("FAIL drain_data c%0d: got %h want %h", c, out_data_v[0], 8'(8'hA0 + c));
        end
      end
      tick();
    end
  endtask

  task automatic test_bubble_collapse();
    out_rdy = 0;
    for (int c = 0; c < 6; c++) begin
      in_vld  = (c == 0 || c == 3);
      in_data = (c == 0) ? 8'h01 : 8'h02;
      #1;
      n_vec++;
      if (in_rdy_v[0] !== 1'b1) begin
        n_err++;
        $display("FAIL bubble_rdy c%0d: got %b want 1", c, in_rdy_v[0]);
      end
      n_vec++;
      if (out_vld_v[0] !== (c >= 4)) begin
        n_err++;
        $display("FAIL bubble_stall_vld c%0d: got %b want %b", c, out_vld_v[0], (c >= 4));
      end
      tick();
    end
    in_vld  = 0;
    out_rdy = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (out_vld_v[0] !== (c < 2)) begin
        n_err++;
        $display("FAIL bubble_vld c%0d: got %b want %b", c, out_vld_v[0], (c < 2));
      end
      if (c < 2) begin
        n_vec++;
        if (out_data_v[0] !== 8'(c + 1)) begin
          n_err++;
          $display("FAIL bubble_data c%0d: got %h want %h", c, out_data_v[0], 8'(c + 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    out_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      in_vld  = 1;
      in_data = 8'(8'hC0 + c);
      tick();
    end
    flush = 1; in_vld = 1; in_data = 8'h55;
    #1;
    n_vec++;
    if (in_rdy_v[0] !== 1'b0 || cnt_v[0] !== 4'd3) begin
      n_err++;
      $display("FAIL flush_cycle: in_rdy=%b count=%0d want 0/3", in_rdy_v[0], cnt_v[0]);
    end
    tick();
    flush = 0; in_vld = 0; out_rdy = 1;
    for (int c = 0; c < 7; c++) begin
      #1;
      n_vec++;
      if (out_vld_v[0] !== 1'b0 || cnt_v[0] !== 4'd0) begin
        n_err++;
        $display("FAIL flush_after c%0d: out_vld=%b count=%0d want 0/0", c, out_vld_v[0], cnt_v[0]);
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    out_rdy = 0;
    for (int c = 0; c < 5; c++) begin
      in_vld  = (c < 3);
      in_data = 8'(8'hD0 + c);
      tick();
    end
    in_vld = 0;
    #1;
    n_vec++;
    if (out_vld_v[0] !== 1'b1 || cnt_v[0] !== 4'd3) begin
      n_err++;
      $display("FAIL rstmid_pre: out_vld=%b count=%0d want 1/3", out_vld_v[0], cnt_v[0]);
    end
    #1;
    rst = 0;
    #1;
    n_vec++;
    if (out_vld_v[0] !== 1'b0 || cnt_v[0] !== 4'd0) begin
      n_err++;
      $display("FAIL rstmid_async: out_vld=%b count=%0d want 0/0", out_vld_v[0], cnt_v[0]);
    end
    tick();
    rst = 1; out_rdy = 1; in_vld = 1; in_data = 8'h77;
    #1;
    n_vec++;
    if (in_rdy_v[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_rdy: got %b want 1", in_rdy_v[0]);
    end
    tick();
    in_vld = 0;
    for (int c = 1; c < 7; c++) begin
      #1;
      n_vec++;
      if (out_vld_v[0] !== (c == 4)) begin
        n_err++;
        $display("FAIL rstmid_vld c%0d: got %b want %b", c, out_vld_v[0], (c == 4));
      end
      if (c == 4) begin
        n_vec++;
        if (out_data_v[0] !== 8'h77) begin
          n_err++;
          $display("FAIL rstmid_data: got %h want 77", out_data_v[0]);
        end
      end
      tick();
    end
  endtask

  // Reference: each instance is an in-order queue of capacity `depth`.
  // The head word is visible once `depth` cycles have passed since its
  // acceptance; input is accepted when not flushing and either a slot is
  // free or the consumer is draining.
  logic [7:0] qd [4][$];
  int         qt [4][$];

  task automatic test_random();
    int   now;
    int   bias;
    logic exp_rdy, exp_ov;
    logic ix [4];
    logic ox [4];
    logic [7:0] d_s;
    logic       fl_s;
    flush = 0; in_vld = 0; out_rdy = 1;
    rst = 0;
    tick();
    rst = 1;
    for (int g = 0; g < 4; g++) begin
      qd[g].delete();
      qt[g].delete();
    end
    now = 0;
    for (int n = 0; n < 3000; n++) begin
      bias    = ((n / 300) % 3 == 0) ? 85 : ((n / 300) % 3 == 1) ? 25 : 55;
      in_vld  = ($urandom_range(99) < 60);
      out_rdy = ($urandom_range(99) < bias);
      flush   = ($urandom_range(99) == 0);
      in_data = 8'($urandom);
      #1;
      for (int g = 0; g < 4; g++) begin
        exp_rdy = !flush && (qd[g].size() < dep(g) || out_rdy);
        exp_ov  = (qd[g].size() > 0) && (now - qt[g][0] >= dep(g));
        n_vec++;
        if (in_rdy_v[g] !== exp_rdy) begin
          n_err++;
          $display("FAIL rand_rdy d%0d t%0d: got %b want %b", dep(g), now, in_rdy_v[g], exp_rdy);
        end
        n_vec++;
        if (out_vld_v[g] !== exp_ov) begin
          n_err++;
          $display("FAIL rand_vld d%0d t%0d: got %b want %b", dep(g), now, out_vld_v[g], exp_ov);
        end
        if (exp_ov) begin
          n_vec++;
          if (out_data_v[g] !== qd[g][0]) begin
            n_err++;
            $display("FAIL rand_data d%0d t%0d: got %h want %h", dep(g), now, out_data_v[g], qd[g][0]);
          end
        end
        n_vec++;
        if (cnt_v[g] !== 4'(qd[g].size())) begin
          n_err++;
          $display("FAIL rand_count d%0d t%0d: got %0d want %0d", dep(g), now, cnt_v[g], qd[g].size());
        end
        ix[g] = in_vld && exp_rdy;
        ox[g] = exp_ov && out_rdy;
      end
      d_s  = in_data;
      fl_s = flush;
      tick();
      for (int g = 0; g < 4; g++) begin
        if (ox[g]) begin
          void'(qd[g].pop_front());
          void'(qt[g].pop_front());
        end
        if (fl_s) begin
          qd[g].delete();
          qt[g].delete();
        end else if (ix[g]) begin
          qd[g].push_back(d_s);
          qt[g].push_back(now);
        end
      end
      now++;
    end
    flush = 0; in_vld = 0;
  endtask

  initial begin
    rst = 0; flush = 0; in_vld = 0; in_data = 0; out_rdy = 1;
    test_reset();
    test_no_backpressure();
    test_fill_full();
    test_bubble_collapse();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
